// File: rtl/muldiv_if.sv
// Request/response bundle between the EX-stage hazard logic and the iterative mul/div unit.
// The master issues operations; the slave (muldiv_unit) reports status and the result.
interface muldiv_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 3
);
  logic                  start;
  logic [OP_WIDTH-1:0]   op;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  flush;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] Result;

  modport master (
    output start, op, SrcA, SrcB, flush,
    input  ready, busy, done, Result
  );

  modport slave (
    input  start, op, SrcA, SrcB, flush,
    output ready, busy, done, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// operating on magnitudes with the result sign reapplied in a single fix-up cycle.
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 3
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int unsigned CntWidth = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned W        = DATA_WIDTH;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [W-1:0]        b_q, b_d;
  logic [2*W-1:0]      acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [W-1:0]        result_q, result_d;

  logic           ready, accept, is_div, a_signed, b_signed, neg_a, neg_b;
  logic [W-1:0]   mag_a, mag_b, special_res, quo, rem, fix_res;
  logic           div_zero, div_ovf, special;
  logic [W:0]     mul_sum, rem_sh, diff;
  logic [2*W-1:0] mul_next, div_next, prod;

  assign ready      = (state_q == StIdle) || (state_q == StDone);
  assign bus.ready  = ready;
  assign bus.busy   = (state_q == StCalc) || (state_q == StFix);
  assign bus.done   = (state_q == StDone);
  assign bus.Result = result_q;

  // Operand conditioning for the incoming request; op[2] selects divide, op[0] unsigned divide.
  assign accept   = bus.start & ready & ~bus.flush;
  assign is_div   = bus.op[2];
  assign a_signed = is_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01) || (bus.op[1:0] == 2'b10);
  assign b_signed = is_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
  assign neg_a    = a_signed & bus.SrcA[W-1];
  assign neg_b    = b_signed & bus.SrcB[W-1];
  assign mag_a    = neg_a ? -bus.SrcA : bus.SrcA;
  assign mag_b    = neg_b ? -bus.SrcB : bus.SrcB;

  assign div_zero = is_div & (bus.SrcB == '0);
  assign div_ovf  = is_div & ~bus.op[0] & (bus.SrcA == {1'b1, {(W-1){1'b0}}}) &
                    (bus.SrcB == '1);
  assign special  = div_zero | div_ovf;
  // op[1] distinguishes REM/REMU from DIV/DIVU.
  assign special_res = div_zero ? (bus.op[1] ? bus.SrcA : '1) :
                                  (bus.op[1] ? '0 : bus.SrcA);

  // Multiply step: conditionally add multiplicand into the upper half, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Restoring divide step: remainder in the upper half, dividend/quotient in the lower half.
  assign rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign diff     = rem_sh - {1'b0, b_q};
  assign div_next = diff[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                            : {diff[W-1:0], acc_q[W-2:0], 1'b1};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem  = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    fix_res = '0;
    if (op_q[2]) begin
      fix_res = op_q[1] ? rem : quo;
    end else begin
      fix_res = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (bus.flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            op_d  = bus.op;
            b_d   = is_div ? mag_b : mag_a;
            acc_d = {{W{1'b0}}, is_div ? mag_a : mag_b};
            neg_d = (is_div && bus.op[1]) ? neg_a : (neg_a ^ neg_b);
            cnt_d = CntWidth'(DATA_WIDTH);
            if (special) begin
              result_d = special_res;
              state_d  = StDone;
            end else begin
              state_d = StCalc;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StCalc: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - CntWidth'(1);
          if (cnt_q == CntWidth'(1)) begin
            state_d = StFix;
          end
        end
        StFix: begin
          result_d = fix_res;
          state_d  = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M corner cases plus randomized operations checked
// against an arithmetic reference model, with latency, back-to-back, flush and reset checks.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  muldiv_if #(.DATA_WIDTH(32), .OP_WIDTH(3)) bus ();

  muldiv_unit #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    logic [31:0]     r;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (o)
      3'd0: begin up = 64'(a) * 64'(b); r = up[31:0]; end
      3'd1: begin sp = longint'(sa) * longint'(sb); r = sp[63:32]; end
      3'd2: begin sp = longint'(sa) * longint'(64'(b)); r = sp[63:32]; end
      3'd3: begin up = 64'(a) * 64'(b); r = up[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = 32'(sa / sb);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Present a request before an edge; after the accept edge scramble inputs to prove latching.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.SrcA  = a;
    bus.SrcB  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.SrcA  = $urandom;
    bus.SrcB  = $urandom;
  endtask

  // lat counts edges from the accept edge (inclusive) up to the one that raised done.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 1;
    nbusy = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) nbusy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b);
    int lat, nbusy;
    bit sp;
    sp = is_special(o, a, b);
    issue(o, a, b);
    wait_done(lat, nbusy);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_lat"}, 32'(lat), sp ? 32'd1 : 32'd34);
    check({tag, "_busy"}, 32'(nbusy), sp ? 32'd0 : 32'd33);
    check({tag, "_res"}, bus.Result, model(o, a, b));
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir [11] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
    '{3'd5, 32'd100,        32'd7,         32'd14},
    '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF},
    '{3'd6, 32'd5,          32'd0,         32'd5},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0}
  };

  initial begin
    int          lat, nbusy, seen;
    logic [2:0]  o;
    logic [31:0] a, b, prev;

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.Result, 32'd0);

    foreach (dir[i]) begin
      run_check($sformatf("dir%0d", i), dir[i].op, dir[i].a, dir[i].b);
      check($sformatf("dir%0d_exp", i), bus.Result, dir[i].exp);
      @(posedge clk);
      #1;
    end

    // Back-to-back: a start presented while done is high must be accepted.
    issue(3'd0, 32'd12345, 32'd678);
    wait_done(lat, nbusy);
    check("b2b_first", bus.Result, model(3'd0, 32'd12345, 32'd678));
    check("b2b_ready_in_done", 32'(bus.ready), 32'd1);
    run_check("b2b_second", 3'd5, 32'd1000, 32'd33);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 500); b = $urandom_range(1, 40); end
        3: begin a = -$urandom_range(0, 500); b = $urandom_range(1, 40); end
        4: b = -$urandom_range(1, 40);
        default: ;
      endcase
      run_check($sformatf("rnd%0d_op%0d", i, o), o, a, b);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    // Flush in the middle of CALC: back to idle, no done, Result untouched.
    @(posedge clk);
    #1;
    prev = bus.Result;
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_ready", 32'(bus.ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen++;
      @(posedge clk);
      #1;
    end
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_result_kept", bus.Result, prev);

    // flush together with start: nothing is accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 3'd0;
    bus.SrcA  = 32'd3;
    bus.SrcB  = 32'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_start_busy", 32'(bus.busy), 32'd0);
    check("flush_start_done", 32'(bus.done), 32'd0);

    // Reset in the middle of CALC.
    issue(3'd1, 32'h7654_3210, 32'h0FED_CBA9);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.Result, 32'd0);

    run_check("post_rst", 3'd6, 32'hFFFF_FF00, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
